player_mover: RTL and testbench

PLAYER_MOVER -- requirements
Module: player_mover

---
 rtl/player_mover.sv | 176 +++++++++++++++++
 tb/tb_player_mover.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_mover.sv
// Purpose : moves a 4x4 sprite down the 160x120 screen one row per step, steered left/right.
// Latency : a step costs 34 cycles (16 erase + 1 update + 16 draw + 1 done) after the triggering tick.
// Backpr. : none on the pixel port; halt freezes motion only between steps, never mid-step.
//
// Ports:
//   clock, resetn             single clock, asynchronous active-low reset
//   frame_tick                one-cycle pulse per video frame
//   go, halt                  play-state level, freeze-motion level
//   move_left, move_right     steering levels, sampled only in the UPDATE cycle
//   x_out, y_out, colour_out  pixel address/colour, zero whenever plot is low
//   plot                      pixel write strobe
//   y_coord                   bottom row of the sprite (top row + 3)
//   busy, done_frame          step in progress, one-cycle end-of-drawing pulse
//
// Build option: define PLAYER_HWRAP_EN to make horizontal motion wrap at the
// screen edges instead of clamping.
module player_mover #(
    parameter logic [2:0] SPRITE_COLOUR  = 3'b110,
    parameter logic [2:0] BG_COLOUR      = 3'b000,
    parameter int         TICKS_PER_STEP = 4,
    parameter logic [7:0] X_START        = 8'd78,
    parameter logic [6:0] Y_START        = 7'd0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       go,
    input  logic       halt,
    input  logic       move_left,
    input  logic       move_right,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic [6:0] y_coord,
    output logic       busy,
    output logic       done_frame
);

    // Largest legal top-left so the 4x4 sprite stays on a 160x120 screen.
    localparam logic [7:0] X_MAX = 8'd156;
    localparam logic [6:0] Y_MAX = 7'd116;
    localparam logic [3:0] TPS   = 4'(TICKS_PER_STEP);

    typedef enum logic [2:0] {
        IDLE,
        INIT_DRAW,
        WAIT,
        ERASE,
        UPDATE,
        DRAW,
        DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] x_pos, x_nxt;
    logic [6:0] y_top, y_nxt;
    logic [3:0] pix_cnt, pix_nxt;
    logic [3:0] tick_cnt, tick_nxt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            x_pos    <= X_START;
            y_top    <= Y_START;
            pix_cnt  <= 4'd0;
            tick_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            x_pos    <= x_nxt;
            y_top    <= y_nxt;
            pix_cnt  <= pix_nxt;
            tick_cnt <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        x_nxt      = x_pos;
        y_nxt      = y_top;
        pix_nxt    = pix_cnt;
        tick_nxt   = tick_cnt;
        plot       = 1'b0;
        busy       = 1'b0;
        done_frame = 1'b0;
        colour_out = 3'b000;

        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = INIT_DRAW;
                    pix_nxt   = 4'd0;
                end
            end
            INIT_DRAW: begin
                plot       = 1'b1;
                colour_out = SPRITE_COLOUR;
                pix_nxt    = pix_cnt + 4'd1;
                if (pix_cnt == 4'd15) state_nxt = DONE;
            end
            WAIT: begin
                // Dropping go wins over a tick; halt freezes the tick count.
                if (!go) begin
                    state_nxt = IDLE;
                    tick_nxt  = 4'd0;
                end else if (!halt && frame_tick) begin
                    if (tick_cnt + 4'd1 == TPS) begin
                        tick_nxt  = 4'd0;
                        pix_nxt   = 4'd0;
                        state_nxt = ERASE;
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            ERASE: begin
                plot       = 1'b1;
                busy       = 1'b1;
                colour_out = BG_COLOUR;
                pix_nxt    = pix_cnt + 4'd1;
                if (pix_cnt == 4'd15) state_nxt = UPDATE;
            end
            UPDATE: begin
                busy      = 1'b1;
                state_nxt = DRAW;
                pix_nxt   = 4'd0;
                if (y_top < Y_MAX) y_nxt = y_top + 7'd1;
                if (move_left && !move_right) begin
                    if (x_pos == 8'd0) begin
`ifdef PLAYER_HWRAP_EN
                        x_nxt = X_MAX;
`else
                        x_nxt = 8'd0;
`endif
                    end else begin
                        x_nxt = x_pos - 8'd1;
                    end
                end else if (move_right && !move_left) begin
                    if (x_pos >= X_MAX) begin
`ifdef PLAYER_HWRAP_EN
                        x_nxt = 8'd0;
`else
                        x_nxt = X_MAX;
`endif
                    end else begin
                        x_nxt = x_pos + 8'd1;
                    end
                end
            end
            DRAW: begin
                plot       = 1'b1;
                busy       = 1'b1;
                colour_out = SPRITE_COLOUR;
                pix_nxt    = pix_cnt + 4'd1;
                if (pix_cnt == 4'd15) state_nxt = DONE;
            end
            DONE: begin
                done_frame = 1'b1;
                state_nxt  = WAIT;
            end
            default: state_nxt = IDLE;
        endcase

        // Row-major walk of the 4x4 sprite: low offset bits are the column.
        if (plot) begin
            x_out = x_pos + {6'd0, pix_cnt[1:0]};
            y_out = y_top + {5'd0, pix_cnt[3:2]};
        end else begin
            x_out = 8'd0;
            y_out = 7'd0;
        end
    end

    assign y_coord = y_top + 7'd3;

endmodule

// File: tb/tb_player_mover.sv
module tb_player_mover;

    localparam int         TPS = 4;
    localparam logic [2:0] SPR = 3'b110;
    localparam logic [2:0] BG  = 3'b000;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       go = 1'b0;
    logic       halt = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic [6:0] y_coord;
    logic       busy;
    logic       done_frame;

    player_mover #(
        .SPRITE_COLOUR (SPR),
        .BG_COLOUR     (BG),
        .TICKS_PER_STEP(TPS),
        .X_START       (8'd78),
        .Y_START       (7'd0)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .frame_tick(frame_tick),
        .go        (go),
        .halt      (halt),
        .move_left (move_left),
        .move_right(move_right),
        .x_out     (x_out),
        .y_out     (y_out),
        .colour_out(colour_out),
        .plot      (plot),
        .y_coord   (y_coord),
        .busy      (busy),
        .done_frame(done_frame)
    );

    always #5 clock = ~clock;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of upcoming per-cycle activities. When the
    // queue is empty the sprite is either idle or waiting for ticks.
    // ------------------------------------------------------------------
    typedef enum {K_INIT, K_ERASE, K_UPD, K_DRAW, K_DONE} kind_e;
    typedef struct {
        kind_e k;
        int    idx;
    } op_t;

    op_t q[$];
    int  mx = 78;
    int  my = 0;
    int  mticks = 0;
    bit  m_play = 0;

    task automatic push_op(input kind_e k, input int n);
        op_t o;
        for (int i = 0; i < n; i++) begin
            o.k   = k;
            o.idx = i;
            q.push_back(o);
        end
    endtask

    always @(negedge clock) begin : cmp
        logic       e_plot, e_busy, e_done;
        logic [2:0] ec;
        int         ex, ey;
        logic [27:0] act_v, exp_v;

        if (!resetn) begin
            q.delete();
            mx = 78; my = 0; mticks = 0; m_play = 0;
        end

        e_plot = 0; e_busy = 0; e_done = 0; ec = 3'b000; ex = 0; ey = 0;
        if (q.size() > 0) begin
            case (q[0].k)
                K_INIT:  begin e_plot = 1; ec = SPR; end
                K_ERASE: begin e_plot = 1; e_busy = 1; ec = BG; end
                K_UPD:   e_busy = 1;
                K_DRAW:  begin e_plot = 1; e_busy = 1; ec = SPR; end
                K_DONE:  e_done = 1;
                default: ;
            endcase
            if (e_plot) begin
                ex = mx + q[0].idx % 4;
                ey = my + q[0].idx / 4;
            end
        end

        act_v = {plot, busy, done_frame, x_out, y_out, colour_out, y_coord};
        exp_v = {e_plot, e_busy, e_done, 8'(ex), 7'(ey), ec, 7'(my + 3)};
        check("cycle", 32'(act_v), 32'(exp_v));

        if (resetn) begin
            if (q.size() > 0) begin
                if (q[0].k == K_UPD) begin
                    if (my < 116) my = my + 1;
                    if (move_left && !move_right) begin
`ifdef PLAYER_HWRAP_EN
                        mx = (mx == 0) ? 156 : mx - 1;
`else
                        mx = (mx == 0) ? 0 : mx - 1;
`endif
                    end else if (move_right && !move_left) begin
`ifdef PLAYER_HWRAP_EN
                        mx = (mx == 156) ? 0 : mx + 1;
`else
                        mx = (mx == 156) ? 156 : mx + 1;
`endif
                    end
                end
                void'(q.pop_front());
            end else if (m_play) begin
                if (!go) begin
                    m_play = 0;
                    mticks = 0;
                end else if (!halt && frame_tick) begin
                    mticks++;
                    if (mticks == TPS) begin
                        mticks = 0;
                        push_op(K_ERASE, 16);
                        push_op(K_UPD, 1);
                        push_op(K_DRAW, 16);
                        push_op(K_DONE, 1);
                    end
                end
            end else if (go) begin
                m_play = 1;
                push_op(K_INIT, 16);
                push_op(K_DONE, 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with literal spot checks
    // ------------------------------------------------------------------
    int n_er, n_dr, fe_x, fe_y, fd_x, fd_y;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic record();
        if (busy && plot && colour_out == BG) begin
            if (n_er == 0) begin fe_x = x_out; fe_y = y_out; end
            n_er++;
        end
        if (busy && plot && colour_out == SPR) begin
            if (n_dr == 0) begin fd_x = x_out; fd_y = y_out; end
            n_dr++;
        end
    endtask

    // Feed ticks until a step starts, then run it to the done pulse.
    task automatic step_once();
        int b;
        n_er = 0; n_dr = 0; b = 0;
        frame_tick = 1'b1;
        while (!busy && b < 100) begin cyc(); b++; end
        frame_tick = 1'b0;
        while (!done_frame && b < 200) begin record(); cyc(); b++; end
        check("step_done", 32'(done_frame), 32'd1);
    endtask

    initial begin
        int b, n_pl, f_x, f_y, f_c, l_x, l_y;

        // Reset state
        resetn = 1'b0;
        repeat (3) cyc();
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ycoord", 32'(y_coord), 32'd3);
        resetn = 1'b1;
        repeat (5) cyc();
        check("idle_no_plot", 32'(plot), 32'd0);

        // First draw after go
        go = 1'b1;
        b = 0; n_pl = 0; f_x = 0; f_y = 0; f_c = 0; l_x = 0; l_y = 0;
        while (!done_frame && b < 100) begin
            if (plot) begin
                if (n_pl == 0) begin f_x = x_out; f_y = y_out; f_c = colour_out; end
                l_x = x_out; l_y = y_out;
                n_pl++;
            end
            cyc(); b++;
        end
        check("init_done", 32'(done_frame), 32'd1);
        check("init_npix", 32'(n_pl), 32'd16);
        check("init_first_x", 32'(f_x), 32'd78);
        check("init_first_y", 32'(f_y), 32'd0);
        check("init_colour", 32'(f_c), 32'd6);
        check("init_last_x", 32'(l_x), 32'd81);
        check("init_last_y", 32'(l_y), 32'd3);
        check("init_ycoord", 32'(y_coord), 32'd3);

        // First step
        step_once();
        check("s1_nerase", 32'(n_er), 32'd16);
        check("s1_erase_x", 32'(fe_x), 32'd78);
        check("s1_erase_y", 32'(fe_y), 32'd0);
        check("s1_ndraw", 32'(n_dr), 32'd16);
        check("s1_draw_x", 32'(fd_x), 32'd78);
        check("s1_draw_y", 32'(fd_y), 32'd1);
        check("s1_ycoord", 32'(y_coord), 32'd4);

        // Both steering inputs: no horizontal motion
        move_left = 1'b1; move_right = 1'b1;
        step_once();
        check("both_x", 32'(fd_x), 32'd78);

        // Walk to the left edge, then one more
        move_right = 1'b0;
        repeat (78) step_once();
        check("left_edge_x", 32'(fd_x), 32'd0);
        step_once();
`ifdef PLAYER_HWRAP_EN
        check("left_past_edge_x", 32'(fd_x), 32'd156);
`else
        check("left_past_edge_x", 32'(fd_x), 32'd0);
`endif
        move_left = 1'b0;

        // 81 steps so far; 35 more reach the bottom row
        repeat (35) step_once();
        check("bottom_ycoord", 32'(y_coord), 32'd119);
        step_once();
        check("sat_draw_y", 32'(fd_y), 32'd116);
        check("sat_ycoord", 32'(y_coord), 32'd119);

        // Halt freezes stepping
        cyc();
        halt = 1'b1; frame_tick = 1'b1; n_pl = 0;
        repeat (40) begin cyc(); if (plot) n_pl++; end
        check("halt_no_plot", 32'(n_pl), 32'd0);
        frame_tick = 1'b0; halt = 1'b0;

        // Reset in the middle of DRAW
        frame_tick = 1'b1; b = 0;
        while (!busy && b < 100) begin cyc(); b++; end
        frame_tick = 1'b0;
        n_dr = 0;
        while (n_dr < 8 && b < 200) begin
            cyc(); b++;
            if (busy && plot && colour_out == SPR) n_dr++;
        end
        check("mid_draw_reached", 32'(n_dr), 32'd8);
        resetn = 1'b0;
        #1;
        check("mid_rst_plot", 32'(plot), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_x_out", 32'(x_out), 32'd0);
        check("mid_rst_ycoord", 32'(y_coord), 32'd3);
        repeat (2) cyc();
        resetn = 1'b1;
        b = 0;
        while (!plot && b < 20) begin cyc(); b++; end
        check("post_rst_x", 32'(x_out), 32'd78);
        check("post_rst_y", 32'(y_out), 32'd0);

        // Randomised play
        repeat (3000) begin
            cyc();
            frame_tick = ($urandom_range(0, 2) == 0);
            move_left  = $urandom_range(0, 1) == 1;
            move_right = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            if ($urandom_range(0, 199) == 0) go = ~go;
        end
        frame_tick = 1'b0;
        repeat (2) cyc();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
